// File: rtl/clk_en_nco_pkg.sv
// Shared types and constants for the clock-enable NCO bank.
// Includes a helper for deriving phase increments from target/clock frequencies.
package clk_en_nco_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK,
        ST_HOLDOFF,
        ST_RUN
    } nco_state_e;

    localparam int unsigned AccWDefault  = 32;
    localparam int unsigned HoldWDefault = 16;

    // floor(f_target * 2^acc_w / f_clk) by long division, so no 64-bit overflow for wide acc_w.
    function automatic longint unsigned nco_inc(input longint unsigned f_target_hz,
                                                input longint unsigned f_clk_hz,
                                                input int unsigned     acc_w);
        longint unsigned q;
        longint unsigned r;
        q = f_target_hz / f_clk_hz;
        r = f_target_hz % f_clk_hz;
        for (int unsigned b = 0; b < acc_w; b++) begin
            q = q << 1;
            r = r << 1;
            if (r >= f_clk_hz) begin
                r = r - f_clk_hz;
                q = q | 64'd1;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: increment/phase config registers, phase accumulator, and
// registered carry strobe plus accumulator-MSB square output.
module nco_channel
    import clk_en_nco_pkg::*;
#(
    parameter int unsigned ACC_W = AccWDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_we_i,
    input  logic [ACC_W-1:0] cfg_inc_i,
    input  logic [ACC_W-1:0] cfg_phase_i,
    input  logic             load_i,
    input  logic             run_i,
    output logic             ce_o,
    output logic             sq_o
);

    logic [ACC_W-1:0] inc_q, phase_q, acc_q, acc_d;
    logic             ce_q, ce_d, sq_q, sq_d;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    // Load takes priority; the square output holds across a reload.
    always_comb begin
        acc_d = acc_q;
        ce_d  = 1'b0;
        sq_d  = 1'b0;
        if (load_i) begin
            acc_d = phase_q;
            sq_d  = sq_q;
        end else if (run_i) begin
            acc_d = sum[ACC_W-1:0];
            ce_d  = sum[ACC_W];
            sq_d  = sum[ACC_W-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inc_q   <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            ce_q    <= 1'b0;
            sq_q    <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                inc_q   <= cfg_inc_i;
                phase_q <= cfg_phase_i;
            end
            acc_q <= acc_d;
            ce_q  <= ce_d;
            sq_q  <= sq_d;
        end
    end

    assign ce_o = ce_q;
    assign sq_o = sq_q;

endmodule

// File: rtl/clk_en_nco_bank.sv
// Bank of NCO clock-enable generators gated on a synchronised, held-off PLL lock.
// Holds the lock synchroniser, the run-control FSM and the per-channel config decode.
module clk_en_nco_bank
    import clk_en_nco_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ACC_W       = AccWDefault,
    parameter int unsigned HOLD_W      = HoldWDefault,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              align,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] sq_out,
    output logic              running
);

    logic              lock_meta_q, lock_s_q;
    nco_state_e        state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              running_q;
    logic              hold_done, entry_load, align_load, run_now;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign hold_done  = (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1));
    assign entry_load = (state_q == ST_HOLDOFF) && lock_s_q && hold_done;
    assign run_now    = (state_q == ST_RUN);
    assign align_load = run_now && align;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_WAIT_LOCK;
            hold_cnt_q <= '0;
            running_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        hold_cnt_q <= '0;
                        state_q    <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (!lock_s_q) begin
                        state_q <= ST_WAIT_LOCK;
                    end else if (hold_done) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_q   <= ST_WAIT_LOCK;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_WAIT_LOCK;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign running = running_q;

    // Out-of-range channel indices match no instance, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nco_channel #(
            .ACC_W(ACC_W)
        ) u_ch (
            .clk_i      (clk),
            .rst_ni     (reset_n),
            .cfg_we_i   (cfg_we && (cfg_ch == CH_W'(i))),
            .cfg_inc_i  (cfg_inc),
            .cfg_phase_i(cfg_phase),
            .load_i     (entry_load || align_load),
            .run_i      (run_now),
            .ce_o       (ce_out[i]),
            .sq_o       (sq_out[i])
        );
    end

endmodule

// File: tb/tb_clk_en_nco_bank.sv
// Randomised self-checking bench for clk_en_nco_bank against a frequency-level model,
// plus directed literal checks of lock latency, strobe spacing, align and reset.
module tb_clk_en_nco_bank;
    import clk_en_nco_pkg::*;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned ACC_W       = 32;
    localparam int unsigned HOLD_W      = 16;
    localparam int unsigned HOLD_CYCLES = 16;
    localparam int unsigned CH_W        = 2;
    localparam longint unsigned AccMask = (64'd1 << ACC_W) - 64'd1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              pll_locked = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic [ACC_W-1:0]  cfg_phase = '0;
    logic              align = 1'b0;
    logic [NUM_CH-1:0] ce_out, sq_out;
    logic              running;

    int checks = 0;
    int errors = 0;

    clk_en_nco_bank #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .HOLD_W     (HOLD_W),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CH_W       (CH_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pll_locked(pll_locked),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .align     (align),
        .ce_out    (ce_out),
        .sq_out    (sq_out),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: running follows a count of consecutive synchronised-lock samples; each
    // channel is a plain modular phase accumulator whose wrap is the strobe.
    bit                 m_meta, m_lock, m_run;
    int                 m_stable;
    longint unsigned    m_inc[NUM_CH], m_phase[NUM_CH], m_acc[NUM_CH];
    bit [NUM_CH-1:0]    m_ce, m_sq;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_meta = 0; m_lock = 0; m_run = 0; m_stable = 0; m_ce = '0; m_sq = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_inc[i] = 0; m_phase[i] = 0; m_acc[i] = 0;
            end
        end else begin
            int              stable_next;
            bit              run_next;
            longint unsigned s;
            if (!m_lock) stable_next = 0;
            else if (m_stable > int'(HOLD_CYCLES)) stable_next = m_stable;
            else stable_next = m_stable + 1;
            run_next = (stable_next >= int'(HOLD_CYCLES) + 1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_run && align) begin
                    m_acc[i] = m_phase[i];
                    m_ce[i]  = 0;
                end else if (m_run) begin
                    s = m_acc[i] + m_inc[i];
                    m_ce[i]  = s[ACC_W];
                    m_sq[i]  = s[ACC_W-1];
                    m_acc[i] = s & AccMask;
                end else begin
                    if (run_next) m_acc[i] = m_phase[i];
                    m_ce[i] = 0;
                    m_sq[i] = 0;
                end
            end
            if (cfg_we && int'(cfg_ch) < int'(NUM_CH)) begin
                m_inc[cfg_ch]   = cfg_inc;
                m_phase[cfg_ch] = cfg_phase;
            end
            m_lock   = m_meta;
            m_meta   = pll_locked;
            m_run    = run_next;
            m_stable = stable_next;
        end
    end

    initial forever begin
        @(negedge clk);
        check("running_vs_model", 64'(running), 64'(m_run));
        check("ce_out_vs_model", 64'(ce_out), 64'(m_ce));
        check("sq_out_vs_model", 64'(sq_out), 64'(m_sq));
    end

    task automatic cfg_write(input int ch, input logic [ACC_W-1:0] inc,
                             input logic [ACC_W-1:0] ph);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_inc = inc; cfg_phase = ph;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_running(output int n);
        n = 0;
        while (!running && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n, cnt0, cnt2, first1, second1;
        logic sq_k2, sq_k4;

        check("nco_inc_48k_at_100m", nco_inc(48000, 100_000_000, 32), 64'd2061584);

        #2 reset_n = 1'b0;
        #20;
        check("reset_ce", 64'(ce_out), 64'd0);
        check("reset_sq", 64'(sq_out), 64'd0);
        check("reset_running", 64'(running), 64'd0);
        @(negedge clk) reset_n = 1'b1;

        cfg_write(0, 32'h4000_0000, 32'h0000_0000);
        cfg_write(1, 32'h0100_0000, 32'hFF00_0000);
        cfg_write(2, 32'h0000_0000, 32'h1234_5678);

        @(negedge clk) pll_locked = 1'b1;
        wait_running(n);
        check("lock_to_run_latency_in_17_19", 64'((n - 1 >= 17) && (n - 1 <= 19)), 64'd1);

        cnt0 = 0; cnt2 = 0; first1 = -1; second1 = -1; sq_k2 = 0; sq_k4 = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (k <= 40 && ce_out[0]) cnt0++;
            if (ce_out[2]) cnt2++;
            if (ce_out[1]) begin
                if (first1 < 0) first1 = k;
                else if (second1 < 0) second1 = k;
            end
            if (k == 2) sq_k2 = sq_out[0];
            if (k == 4) sq_k4 = sq_out[0];
        end
        check("ch0_strobes_in_40", 64'(cnt0), 64'd10);
        check("ch0_sq_k2_high", 64'(sq_k2), 64'd1);
        check("ch0_sq_k4_low", 64'(sq_k4), 64'd0);
        check("ch1_first_strobe", 64'(first1), 64'd1);
        check("ch1_second_strobe", 64'(second1), 64'd257);
        check("ch2_inc0_no_strobe", 64'(cnt2), 64'd0);

        cfg_write(0, 32'h4000_0000, 32'h8000_0000);
        align = 1'b1;
        @(posedge clk); #1;
        check("align_ce_clear", 64'(ce_out), 64'd0);
        @(negedge clk) align = 1'b0;
        @(posedge clk); #1;
        check("align_ch0_k1", 64'(ce_out[0]), 64'd0);
        @(posedge clk); #1;
        check("align_ch0_k2", 64'(ce_out[0]), 64'd1);

        cfg_write(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cnt0 = 0; cnt2 = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ce_out[0]) cnt0++;
            if (ce_out[2]) cnt2++;
        end
        check("bad_ch_ch0_rate", 64'(cnt0), 64'd2);
        check("bad_ch_ch2_quiet", 64'(cnt2), 64'd0);

        @(negedge clk) pll_locked = 1'b0;
        n = 0;
        while (running && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("unlock_drop_within_3", 64'((n >= 1) && (n <= 3)), 64'd1);
        @(posedge clk); #1;
        check("unlock_ce_clear", 64'(ce_out), 64'd0);
        check("unlock_sq_clear", 64'(sq_out), 64'd0);
        @(negedge clk) pll_locked = 1'b1;
        wait_running(n);
        check("relock_full_holdoff", 64'((n - 1 >= 17) && (n - 1 <= 19)), 64'd1);

        begin
            int low_left = 0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (low_left > 0) begin
                    pll_locked = 1'b0;
                    low_left--;
                end else begin
                    pll_locked = 1'b1;
                    if ($urandom_range(0, 399) == 0) low_left = $urandom_range(1, 6);
                end
                align = ($urandom_range(0, 31) == 0);
                cfg_we = ($urandom_range(0, 7) == 0);
                cfg_ch = CH_W'($urandom_range(0, 3));
                cfg_phase = $urandom;
                case ($urandom_range(0, 4))
                    0: cfg_inc = '0;
                    1: cfg_inc = '1;
                    2: cfg_inc = $urandom;
                    3: cfg_inc = 32'h8000_0000;
                    default: cfg_inc = ACC_W'($urandom_range(1, 65535)) << 16;
                endcase
            end
            @(negedge clk);
            cfg_we = 1'b0; align = 1'b0; pll_locked = 1'b1;
        end

        wait_running(n);
        check("running_before_reset", 64'(running), 64'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_ce", 64'(ce_out), 64'd0);
        check("async_reset_sq", 64'(sq_out), 64'd0);
        check("async_reset_running", 64'(running), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        wait_running(n);
        check("rerun_after_reset", 64'(running), 64'd1);
        cnt0 = 0; cnt2 = 0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            if (ce_out != '0) cnt0++;
            if (sq_out != '0) cnt2++;
        end
        check("no_strobe_unprogrammed", 64'(cnt0), 64'd0);
        check("no_sq_unprogrammed", 64'(cnt2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
